// File: rtl/midi_pkg.sv
// ---------------------------------------------------------------------------
// midi_pkg
// Shared types and constants for the MIDI burst builder.
//   - MIDI status nibbles and the realtime threshold
//   - parser state encoding
//   - parsed message record handed from the parser to the slot allocator
//   - slot_word(): packs a note/velocity pair into a 16-bit slot word
// ---------------------------------------------------------------------------
package midi_pkg;

   localparam logic [3:0] NOTE_OFF     = 4'h8;
   localparam logic [3:0] NOTE_ON      = 4'h9;
   localparam logic [7:0] REALTIME_MIN = 8'hF8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA1 = 2'd1,
      DATA2 = 2'd2,
      SKIP  = 2'd3
   } parser_state_e;

   typedef struct packed {
      logic       is_on;
      logic [6:0] note;
      logic [6:0] vel;
   } midi_msg_t;

   // Slot word layout: [15:8] note number, [7:0] velocity (both 7-bit values).
   function automatic logic [15:0] slot_word(input logic [6:0] note, input logic [6:0] vel);
      return {1'b0, note, 1'b0, vel};
   endfunction

endpackage

// File: rtl/midi_burst_builder_if.sv
// ---------------------------------------------------------------------------
// midi_burst_builder_if
// Burst interface between the MIDI burst builder (master) and the synthesis
// combiner (slave).
//   on_array_out          bit i = slot i holds a sounding note
//   midi_burst_data_out   per slot {note, velocity}
//   midi_burst_change_out one-cycle pulse, burst contents changed
//   voice_drop_out        one-cycle pulse, a Note On found no free slot
//   active_count_out      number of sounding slots
// ---------------------------------------------------------------------------
interface midi_burst_builder_if #(
   parameter int NUM_VOICES = 5
) ();

   logic [NUM_VOICES-1:0] on_array_out;
   logic [15:0]           midi_burst_data_out [NUM_VOICES];
   logic                  midi_burst_change_out;
   logic                  voice_drop_out;
   logic [2:0]            active_count_out;

   modport master (
      output on_array_out,
      output midi_burst_data_out,
      output midi_burst_change_out,
      output voice_drop_out,
      output active_count_out
   );

   modport slave (
      input on_array_out,
      input midi_burst_data_out,
      input midi_burst_change_out,
      input voice_drop_out,
      input active_count_out
   );

endinterface

// File: rtl/midi_msg_parser.sv
// ---------------------------------------------------------------------------
// midi_msg_parser
// Byte-level MIDI parser for Note On / Note Off with running status.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   byte_i, byte_valid_i received byte and its single-cycle valid
//   msg_o, msg_valid_o  completed message, valid for one cycle after the
//                       edge that sampled the velocity byte
// Parameters: OMNI (1 = all channels), CHANNEL (channel used when OMNI=0).
// ---------------------------------------------------------------------------
module midi_msg_parser
   import midi_pkg::*;
#(
   parameter bit         OMNI    = 1'b1,
   parameter logic [3:0] CHANNEL = 4'd0
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] byte_i,
   input  logic       byte_valid_i,
   output midi_msg_t  msg_o,
   output logic       msg_valid_o
);

   parser_state_e state_q, state_d;
   logic          rs_valid_q, rs_valid_d;   // running status present
   logic          rs_on_q, rs_on_d;         // running status is 0x9n
   logic [6:0]    note_q, note_d;
   midi_msg_t     msg_q, msg_d;
   logic          msg_valid_q, msg_valid_d;

   logic is_status;
   logic is_realtime;
   logic is_note_status;
   logic chan_ok;
   logic data2_done;

   assign is_status      = byte_i[7];
   assign is_realtime    = (byte_i >= REALTIME_MIN);
   assign is_note_status = (byte_i[7:4] == NOTE_ON) || (byte_i[7:4] == NOTE_OFF);
   assign chan_ok        = OMNI || (byte_i[3:0] == CHANNEL);
   assign data2_done     = byte_valid_i && !is_status && (state_q == DATA2);

   always_comb begin
      state_d     = state_q;
      rs_valid_d  = rs_valid_q;
      rs_on_d     = rs_on_q;
      note_d      = note_q;
      msg_d       = msg_q;
      msg_valid_d = 1'b0;

      // Realtime bytes may interleave anywhere and leave the parser untouched.
      if (byte_valid_i && !is_realtime) begin
         if (is_status) begin
            if (is_note_status && chan_ok) begin
               rs_valid_d = 1'b1;
               rs_on_d    = (byte_i[7:4] == NOTE_ON);
               state_d    = DATA1;
            end else begin
               // Any other status (or a foreign channel) cancels running status
               // so that its trailing data bytes are not mistaken for notes.
               rs_valid_d = 1'b0;
               state_d    = SKIP;
            end
         end else begin
            case (state_q)
               IDLE: begin
                  if (rs_valid_q) begin
                     note_d  = byte_i[6:0];
                     state_d = DATA2;
                  end
               end
               DATA1: begin
                  note_d  = byte_i[6:0];
                  state_d = DATA2;
               end
               DATA2: begin
                  msg_d.is_on = rs_on_q && (byte_i[6:0] != 7'd0);
                  msg_d.note  = note_q;
                  msg_d.vel   = byte_i[6:0];
                  msg_valid_d = 1'b1;
                  state_d     = IDLE;
               end
               default: ;   // SKIP: data bytes of a message we do not handle
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         rs_valid_q  <= 1'b0;
         rs_on_q     <= 1'b0;
         note_q      <= '0;
         msg_q       <= '0;
         msg_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rs_valid_q  <= rs_valid_d;
         rs_on_q     <= rs_on_d;
         note_q      <= note_d;
         msg_q       <= msg_d;
         msg_valid_q <= msg_valid_d;
      end
   end

   assign msg_o       = msg_q;
   assign msg_valid_o = msg_valid_q;

   // A message needs at least two bytes, so a completed message is always
   // consumed before the next one can complete.
   a_no_pending_overrun: assert property (@(posedge clk_i) disable iff (rst_i)
      !(msg_valid_q && data2_done));

endmodule

// File: rtl/midi_burst_builder.sv
// ---------------------------------------------------------------------------
// midi_burst_builder
// Turns a raw MIDI byte stream into the per-voice burst interface.
// Ports:
//   clk_in, rst_in        clock, asynchronous active-high reset
//   byte_in, byte_valid_in received MIDI byte and its single-cycle valid
//   burst_if              burst interface (master side)
// Pipeline: parser registers the message at edge E (velocity byte), the
// apply stage latches it at E+1, and slot registers update at E+2.
// ---------------------------------------------------------------------------
module midi_burst_builder
   import midi_pkg::*;
#(
   parameter int         NUM_VOICES = 5,
   parameter bit         OMNI       = 1'b1,
   parameter logic [3:0] CHANNEL    = 4'd0
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic [7:0]           byte_in,
   input  logic                 byte_valid_in,
   midi_burst_builder_if.master burst_if
);

   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

   midi_msg_t msg;
   logic      msg_valid;

   midi_msg_parser #(
      .OMNI    (OMNI),
      .CHANNEL (CHANNEL)
   ) u_parser (
      .clk_i        (clk_in),
      .rst_i        (rst_in),
      .byte_i       (byte_in),
      .byte_valid_i (byte_valid_in),
      .msg_o        (msg),
      .msg_valid_o  (msg_valid)
   );

   // Apply stage input register.
   logic      apply_valid_q;
   midi_msg_t apply_msg_q;

   // Voice slot registers.
   logic [NUM_VOICES-1:0] on_q, on_d;
   logic [6:0]            note_q [NUM_VOICES];
   logic [6:0]            note_d [NUM_VOICES];
   logic [6:0]            vel_q  [NUM_VOICES];
   logic [6:0]            vel_d  [NUM_VOICES];
   logic                  change_q, change_d;
   logic                  drop_q, drop_d;
   logic [2:0]            count_q, count_d;

   // Slot search: only sounding slots can match; free means not sounding.
   logic [NUM_VOICES-1:0] match_vec;
   logic [NUM_VOICES-1:0] free_vec;
   logic                  hit_found, free_found;
   logic [IDX_W-1:0]      hit_idx, free_idx;

   for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_search
      assign match_vec[gi] = on_q[gi] && (note_q[gi] == apply_msg_q.note);
      assign free_vec[gi]  = !on_q[gi];
   end

   // Scanning downwards leaves the lowest matching index as the result.
   always_comb begin
      hit_found  = 1'b0;
      hit_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (match_vec[i]) begin
            hit_found = 1'b1;
            hit_idx   = IDX_W'(i);
         end
         if (free_vec[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      on_d     = on_q;
      note_d   = note_q;
      vel_d    = vel_q;
      change_d = 1'b0;
      drop_d   = 1'b0;

      if (apply_valid_q) begin
         if (apply_msg_q.is_on) begin
            if (hit_found) begin
               // Retrigger of a sounding note keeps its slot.
               vel_d[hit_idx] = apply_msg_q.vel;
               change_d       = 1'b1;
            end else if (free_found) begin
               on_d[free_idx]   = 1'b1;
               note_d[free_idx] = apply_msg_q.note;
               vel_d[free_idx]  = apply_msg_q.vel;
               change_d         = 1'b1;
            end else begin
               drop_d = 1'b1;
            end
         end else if (hit_found) begin
            on_d[hit_idx]   = 1'b0;
            note_d[hit_idx] = '0;
            vel_d[hit_idx]  = '0;
            change_d        = 1'b1;
         end
      end

      count_d = 3'($countones(on_d));
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         apply_valid_q <= 1'b0;
         apply_msg_q   <= '0;
         on_q          <= '0;
         change_q      <= 1'b0;
         drop_q        <= 1'b0;
         count_q       <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            note_q[i] <= '0;
            vel_q[i]  <= '0;
         end
      end else begin
         apply_valid_q <= msg_valid;
         apply_msg_q   <= msg;
         on_q          <= on_d;
         note_q        <= note_d;
         vel_q         <= vel_d;
         change_q      <= change_d;
         drop_q        <= drop_d;
         count_q       <= count_d;
      end
   end

   assign burst_if.on_array_out          = on_q;
   assign burst_if.midi_burst_change_out = change_q;
   assign burst_if.voice_drop_out        = drop_q;
   assign burst_if.active_count_out      = count_q;

   for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_data
      assign burst_if.midi_burst_data_out[gi] = slot_word(note_q[gi], vel_q[gi]);
   end

endmodule

// File: tb/tb_midi_burst_builder.sv
// ---------------------------------------------------------------------------
// tb_midi_burst_builder
// Two builders share one byte stream: unit 0 is OMNI, unit 1 listens to
// channel 2 only. A message-level model per unit predicts slot contents and
// pulse counts.
// ---------------------------------------------------------------------------
module tb_midi_burst_builder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] byte_in = 8'h00;
   logic       byte_valid = 1'b0;

   always #5 clk = ~clk;

   midi_burst_builder_if #(.NUM_VOICES(5)) bus_a ();
   midi_burst_builder_if #(.NUM_VOICES(5)) bus_b ();

   midi_burst_builder #(.NUM_VOICES(5), .OMNI(1'b1), .CHANNEL(4'd0)) dut_a (
      .clk_in(clk), .rst_in(rst), .byte_in(byte_in), .byte_valid_in(byte_valid), .burst_if(bus_a));

   midi_burst_builder #(.NUM_VOICES(5), .OMNI(1'b0), .CHANNEL(4'd2)) dut_b (
      .clk_in(clk), .rst_in(rst), .byte_in(byte_in), .byte_valid_in(byte_valid), .burst_if(bus_b));

   // Observed values, indexed by unit.
   logic [4:0]  obs_on   [2];
   logic [79:0] obs_data [2];
   logic [2:0]  obs_cnt  [2];
   logic        obs_chg  [2];
   logic        obs_drop [2];

   assign obs_on[0]   = bus_a.on_array_out;
   assign obs_on[1]   = bus_b.on_array_out;
   assign obs_cnt[0]  = bus_a.active_count_out;
   assign obs_cnt[1]  = bus_b.active_count_out;
   assign obs_chg[0]  = bus_a.midi_burst_change_out;
   assign obs_chg[1]  = bus_b.midi_burst_change_out;
   assign obs_drop[0] = bus_a.voice_drop_out;
   assign obs_drop[1] = bus_b.voice_drop_out;

   for (genvar gi = 0; gi < 5; gi++) begin : g_flat
      assign obs_data[0][16*gi +: 16] = bus_a.midi_burst_data_out[gi];
      assign obs_data[1][16*gi +: 16] = bus_b.midi_burst_data_out[gi];
   end

   // Pulse counters, cleared while reset is held.
   int chg_cnt  [2];
   int drop_cnt [2];

   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (rst) begin
            chg_cnt[u]  = 0;
            drop_cnt[u] = 0;
         end else begin
            if (obs_chg[u])  chg_cnt[u]  = chg_cnt[u] + 1;
            if (obs_drop[u]) drop_cnt[u] = drop_cnt[u] + 1;
         end
      end
   end

   int compared   = 0;
   int mismatched = 0;

   // ---------------- reference model ----------------
   bit         cfg_omni [2] = '{1'b1, 1'b0};
   int         cfg_chan [2] = '{0, 2};
   int         m_rs     [2];           // running status byte, -1 when none
   int         m_nb     [2];           // data bytes collected so far
   logic [6:0] m_d0     [2];
   bit         m_on     [2][5];
   logic [6:0] m_note   [2][5];
   logic [6:0] m_vel    [2][5];
   int         exp_chg  [2];
   int         exp_drop [2];

   function automatic void model_reset();
      for (int u = 0; u < 2; u++) begin
         m_rs[u] = -1; m_nb[u] = 0; m_d0[u] = '0;
         exp_chg[u] = 0; exp_drop[u] = 0;
         for (int i = 0; i < 5; i++) begin
            m_on[u][i] = 1'b0; m_note[u][i] = '0; m_vel[u][i] = '0;
         end
      end
   endfunction

   function automatic void model_apply(int u, bit is_on, logic [6:0] n, logic [6:0] v);
      int hit = -1;
      int fr  = -1;
      for (int i = 0; i < 5; i++) begin
         if (m_on[u][i] && m_note[u][i] == n && hit < 0) hit = i;
         if (!m_on[u][i] && fr < 0) fr = i;
      end
      if (is_on) begin
         if (hit >= 0) begin
            m_vel[u][hit] = v; exp_chg[u]++;
            $display("[%0t] unit%0d note-on  n=%02h v=%02h retrigger slot%0d", $time, u, n, v, hit);
         end else if (fr >= 0) begin
            m_on[u][fr] = 1'b1; m_note[u][fr] = n; m_vel[u][fr] = v; exp_chg[u]++;
            $display("[%0t] unit%0d note-on  n=%02h v=%02h new slot%0d", $time, u, n, v, fr);
         end else begin
            exp_drop[u]++;
            $display("[%0t] unit%0d note-on  n=%02h v=%02h dropped", $time, u, n, v);
         end
      end else if (hit >= 0) begin
         m_on[u][hit] = 1'b0; m_note[u][hit] = '0; m_vel[u][hit] = '0; exp_chg[u]++;
         $display("[%0t] unit%0d note-off n=%02h released slot%0d", $time, u, n, hit);
      end else begin
         $display("[%0t] unit%0d note-off n=%02h not sounding", $time, u, n);
      end
   endfunction

   function automatic void model_byte(logic [7:0] b);
      for (int u = 0; u < 2; u++) begin
         if (b >= 8'hF8) continue;
         if (b >= 8'h80) begin
            m_nb[u] = 0;
            if (b < 8'hA0 && (cfg_omni[u] || b[3:0] == cfg_chan[u])) m_rs[u] = int'(b);
            else m_rs[u] = -1;
         end else if (m_rs[u] >= 0) begin
            if (m_nb[u] == 0) begin
               m_d0[u] = b[6:0]; m_nb[u] = 1;
            end else begin
               m_nb[u] = 0;
               model_apply(u, ((m_rs[u] & 16) != 0) && (b != 8'h00), m_d0[u], b[6:0]);
            end
         end
      end
   endfunction

   function automatic logic [4:0] model_on(int u);
      logic [4:0] r = '0;
      for (int i = 0; i < 5; i++) r[i] = m_on[u][i];
      return r;
   endfunction

   function automatic logic [79:0] model_data(int u);
      logic [79:0] d = '0;
      for (int i = 0; i < 5; i++)
         if (m_on[u][i]) d[16*i +: 16] = {1'b0, m_note[u][i], 1'b0, m_vel[u][i]};
      return d;
   endfunction

   function automatic logic [2:0] model_cnt(int u);
      int c = 0;
      for (int i = 0; i < 5; i++) if (m_on[u][i]) c++;
      return 3'(c);
   endfunction

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic send_byte(input logic [7:0] b);
      byte_in    = b;
      byte_valid = 1'b1;
      model_byte(b);
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic settle();
      repeat (4) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         compared++;
         if (obs_on[u] !== 5'b0 || obs_data[u] !== 80'b0 || obs_cnt[u] !== 3'd0 ||
             obs_chg[u] !== 1'b0 || obs_drop[u] !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_hold u%0d: on=%b cnt=%0d chg=%b drop=%b data=%h required all zero",
                     u, obs_on[u], obs_cnt[u], obs_chg[u], obs_drop[u], obs_data[u]);
         end
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         compared++;
         if (obs_on[u] !== 5'b0 || obs_data[u] !== 80'b0 || obs_cnt[u] !== 3'd0) begin
            mismatched++;
            $display("FAIL reset_release u%0d: on=%b cnt=%0d data=%h required all zero",
                     u, obs_on[u], obs_cnt[u], obs_data[u]);
         end
      end
   endtask

   task automatic test_basic();
      do_reset();
      send_byte(8'h90);
      send_byte(8'h3C);
      send_byte(8'h64);           // returns just after edge E
      compared++;
      if (obs_on[0] !== 5'b0) begin
         mismatched++; $display("FAIL lat_e u0: on=%b required 00000", obs_on[0]);
      end
      @(negedge clk);             // after E+1
      compared++;
      if (obs_on[0] !== 5'b0 || obs_chg[0] !== 1'b0) begin
         mismatched++; $display("FAIL lat_e1 u0: on=%b chg=%b required 00000/0", obs_on[0], obs_chg[0]);
      end
      @(negedge clk);             // after E+2
      compared++;
      if (obs_on[0] !== 5'b00001 || obs_chg[0] !== 1'b1 || obs_data[0][15:0] !== 16'h3C64 ||
          obs_cnt[0] !== 3'd1) begin
         mismatched++;
         $display("FAIL lat_e2 u0: on=%b chg=%b slot0=%h cnt=%0d required 00001/1/3c64/1",
                  obs_on[0], obs_chg[0], obs_data[0][15:0], obs_cnt[0]);
      end
      @(negedge clk);
      compared++;
      if (obs_chg[0] !== 1'b0 || obs_data[0][15:0] !== 16'h3C64) begin
         mismatched++;
         $display("FAIL pulse_width u0: chg=%b slot0=%h required 0/3c64", obs_chg[0], obs_data[0][15:0]);
      end
      settle();
      compared++;
      if (chg_cnt[0] != 1 || obs_on[1] !== 5'b0) begin
         mismatched++;
         $display("FAIL basic_counts: chg_u0=%0d on_u1=%b required 1/00000", chg_cnt[0], obs_on[1]);
      end
   endtask

   task automatic test_running_status();
      send_byte(8'h40);
      send_byte(8'h50);
      settle();
      compared++;
      if (obs_on[0] !== 5'b00011 || obs_data[0][31:16] !== 16'h4050 || chg_cnt[0] != 2) begin
         mismatched++;
         $display("FAIL rs_on u0: on=%b slot1=%h chg=%0d required 00011/4050/2",
                  obs_on[0], obs_data[0][31:16], chg_cnt[0]);
      end
      send_byte(8'h3C);
      send_byte(8'h00);
      settle();
      compared++;
      if (obs_on[0] !== 5'b00010 || obs_data[0][15:0] !== 16'h0000 ||
          obs_data[0][31:16] !== 16'h4050 || chg_cnt[0] != 3 || obs_cnt[0] !== 3'd1) begin
         mismatched++;
         $display("FAIL rs_off u0: on=%b slot0=%h slot1=%h chg=%0d cnt=%0d required 00010/0000/4050/3/1",
                  obs_on[0], obs_data[0][15:0], obs_data[0][31:16], chg_cnt[0], obs_cnt[0]);
      end
   endtask

   task automatic test_voice_full();
      do_reset();
      send_byte(8'h90);
      for (int k = 0; k < 5; k++) begin
         send_byte(8'h30 + 8'(k));
         send_byte(8'h41 + 8'(k));
      end
      settle();
      compared++;
      if (obs_on[0] !== 5'b11111 || obs_data[0] !== model_data(0) || chg_cnt[0] != 5 || obs_cnt[0] !== 3'd5) begin
         mismatched++;
         $display("FAIL full_fill u0: on=%b chg=%0d cnt=%0d data=%h required 11111/5/5/%h",
                  obs_on[0], chg_cnt[0], obs_cnt[0], obs_data[0], model_data(0));
      end
      send_byte(8'h35);
      send_byte(8'h46);
      settle();
      compared++;
      if (obs_on[0] !== 5'b11111 || obs_data[0] !== model_data(0) || chg_cnt[0] != 5 || drop_cnt[0] != 1) begin
         mismatched++;
         $display("FAIL full_drop u0: on=%b chg=%0d drop=%0d required 11111/5/1",
                  obs_on[0], chg_cnt[0], drop_cnt[0]);
      end
      send_byte(8'h80);
      send_byte(8'h32);
      send_byte(8'h40);
      settle();
      compared++;
      if (obs_on[0] !== 5'b11011 || obs_data[0][47:32] !== 16'h0000 || obs_cnt[0] !== 3'd4) begin
         mismatched++;
         $display("FAIL full_free u0: on=%b slot2=%h cnt=%0d required 11011/0000/4",
                  obs_on[0], obs_data[0][47:32], obs_cnt[0]);
      end
      send_byte(8'h90);
      send_byte(8'h36);
      send_byte(8'h55);
      settle();
      compared++;
      if (obs_on[0] !== 5'b11111 || obs_data[0][47:32] !== 16'h3655 || obs_data[0] !== model_data(0)) begin
         mismatched++;
         $display("FAIL full_refill u0: on=%b slot2=%h required 11111/3655", obs_on[0], obs_data[0][47:32]);
      end
   endtask

   task automatic test_realtime_skip();
      do_reset();
      send_byte(8'h90);
      send_byte(8'h3C);
      send_byte(8'hF8);
      send_byte(8'h70);
      settle();
      compared++;
      if (obs_on[0] !== 5'b00001 || obs_data[0][15:0] !== 16'h3C70 || chg_cnt[0] != 1) begin
         mismatched++;
         $display("FAIL realtime u0: on=%b slot0=%h chg=%0d required 00001/3c70/1",
                  obs_on[0], obs_data[0][15:0], chg_cnt[0]);
      end
      send_byte(8'h90);
      send_byte(8'hB0);
      send_byte(8'h07);
      send_byte(8'h7F);
      send_byte(8'h3C);
      send_byte(8'h10);
      settle();
      compared++;
      if (obs_on[0] !== 5'b00001 || obs_data[0] !== {64'b0, 16'h3C70} || chg_cnt[0] != 1 || drop_cnt[0] != 0) begin
         mismatched++;
         $display("FAIL skip_cc u0: on=%b data=%h chg=%0d required 00001/3c70/1",
                  obs_on[0], obs_data[0], chg_cnt[0]);
      end
   endtask

   task automatic test_channel_filter();
      do_reset();
      send_byte(8'h91);
      send_byte(8'h3C);
      send_byte(8'h64);
      settle();
      compared++;
      if (obs_on[1] !== 5'b0 || chg_cnt[1] != 0 || obs_on[0] !== 5'b00001) begin
         mismatched++;
         $display("FAIL chan_reject: on_u1=%b chg_u1=%0d on_u0=%b required 00000/0/00001",
                  obs_on[1], chg_cnt[1], obs_on[0]);
      end
      send_byte(8'h92);
      send_byte(8'h3C);
      send_byte(8'h64);
      settle();
      compared++;
      if (obs_on[1] !== 5'b00001 || obs_data[1][15:0] !== 16'h3C64 || chg_cnt[1] != 1) begin
         mismatched++;
         $display("FAIL chan_accept u1: on=%b slot0=%h chg=%0d required 00001/3c64/1",
                  obs_on[1], obs_data[1][15:0], chg_cnt[1]);
      end
      send_byte(8'h3C);
      send_byte(8'h20);
      settle();
      compared++;
      if (obs_on[1] !== 5'b00001 || obs_data[1][15:0] !== 16'h3C20 || obs_cnt[1] !== 3'd1 || chg_cnt[1] != 2) begin
         mismatched++;
         $display("FAIL chan_retrig u1: on=%b slot0=%h cnt=%0d chg=%0d required 00001/3c20/1/2",
                  obs_on[1], obs_data[1][15:0], obs_cnt[1], chg_cnt[1]);
      end
      compared++;
      if (obs_data[0] !== model_data(0) || chg_cnt[0] != exp_chg[0]) begin
         mismatched++;
         $display("FAIL chan_omni u0: data=%h chg=%0d required %h/%0d",
                  obs_data[0], chg_cnt[0], model_data(0), exp_chg[0]);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      send_byte(8'h92);
      for (int k = 0; k < 12; k++) begin
         send_byte(8'h20 + 8'(k % 6));
         send_byte(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 127)));
      end
      settle();
      for (int u = 0; u < 2; u++) begin
         compared++;
         if (obs_on[u] !== model_on(u) || obs_data[u] !== model_data(u) || obs_cnt[u] !== model_cnt(u) ||
             chg_cnt[u] != exp_chg[u] || drop_cnt[u] != exp_drop[u]) begin
            mismatched++;
            $display("FAIL b2b u%0d: on=%b cnt=%0d chg=%0d drop=%0d required %b/%0d/%0d/%0d",
                     u, obs_on[u], obs_cnt[u], chg_cnt[u], drop_cnt[u],
                     model_on(u), model_cnt(u), exp_chg[u], exp_drop[u]);
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      send_byte(8'h90);
      send_byte(8'h3C);
      send_byte(8'h64);
      send_byte(8'h40);
      send_byte(8'h50);
      settle();
      send_byte(8'h90);
      send_byte(8'h3C);           // unit 0 now waits for a velocity byte
      compared++;
      if (obs_on[0] !== 5'b00011) begin
         mismatched++; $display("FAIL areset_pre u0: on=%b required 00011", obs_on[0]);
      end
      #2 rst = 1'b1;
      #1;
      compared++;
      if (obs_on[0] !== 5'b0 || obs_data[0] !== 80'b0 || obs_cnt[0] !== 3'd0 || obs_chg[0] !== 1'b0) begin
         mismatched++;
         $display("FAIL areset_now u0: on=%b cnt=%0d chg=%b data=%h required all zero",
                  obs_on[0], obs_cnt[0], obs_chg[0], obs_data[0]);
      end
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      send_byte(8'h50);
      settle();
      compared++;
      if (obs_on[0] !== 5'b0 || obs_data[0] !== 80'b0 || chg_cnt[0] != 0) begin
         mismatched++;
         $display("FAIL areset_after u0: on=%b chg=%0d data=%h required 00000/0/0",
                  obs_on[0], chg_cnt[0], obs_data[0]);
      end
   endtask

   task automatic test_random();
      logic [7:0] b;
      int r;
      int d;
      do_reset();
      for (int n = 1; n <= 400; n++) begin
         r = $urandom_range(0, 99);
         if (r < 6)       b = 8'hF8 + 8'($urandom_range(0, 7));
         else if (r < 12) b = 8'hA0 + 8'($urandom_range(0, 87));
         else if (r < 28) b = 8'h80 | 8'($urandom_range(0, 1) << 4) | 8'($urandom_range(0, 3));
         else begin
            d = $urandom_range(0, 9);
            if (d < 2)      b = 8'h00;
            else if (d < 6) b = 8'h30 + 8'($urandom_range(0, 7));
            else            b = 8'($urandom_range(0, 127));
         end
         send_byte(b);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         if (n % 25 == 0) begin
            settle();
            for (int u = 0; u < 2; u++) begin
               compared++;
               if (obs_on[u] !== model_on(u) || obs_data[u] !== model_data(u) || obs_cnt[u] !== model_cnt(u) ||
                   chg_cnt[u] != exp_chg[u] || drop_cnt[u] != exp_drop[u]) begin
                  mismatched++;
                  $display("FAIL random@%0d u%0d: on=%b cnt=%0d chg=%0d drop=%0d data=%h required %b/%0d/%0d/%0d/%h",
                           n, u, obs_on[u], obs_cnt[u], chg_cnt[u], drop_cnt[u], obs_data[u],
                           model_on(u), model_cnt(u), exp_chg[u], exp_drop[u], model_data(u));
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_running_status();
      test_voice_full();
      test_realtime_skip();
      test_channel_filter();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
